i4002: RTL

MCS-4 data RAM and output-port responder: the `cm_ram` end of the 4004 bus, mirroring how the 4001 answers `cm_rom`. It tracks the 8-phase instruction cycle from `sync`, and latches chip/register/character selection from SRC. On CPU I/O opcodes (OPR=`E`) it performs RAM, status and output-port reads and writes. It sits beside the 4001 on the shared 4-bit bus in the MCS-4 top level and testbench.

---
 rtl/mcs4_pkg.sv | 40 ++++
 rtl/mcs4_phase_tracker.sv | 40 ++++
 rtl/i4002.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/mcs4_pkg.sv
// Shared MCS-4 bus types and I/O opcode constants used by the 4001/4002 responders
// and the instruction-phase tracker.
package mcs4;

  typedef logic [3:0] char_t;
  typedef logic [1:0] ram_reg_t;

  typedef enum logic [3:0] {
    WAIT = 4'd0,
    A1   = 4'd1,
    A2   = 4'd2,
    A3   = 4'd3,
    M1   = 4'd4,
    M2   = 4'd5,
    X1   = 4'd6,
    X2   = 4'd7,
    X3   = 4'd8
  } phase_t;

  localparam char_t OPR_IO  = 4'hE;

  localparam char_t OPA_WRM = 4'h0;
  localparam char_t OPA_WMP = 4'h1;
  localparam char_t OPA_WR0 = 4'h4;
  localparam char_t OPA_SBM = 4'h8;
  localparam char_t OPA_RDM = 4'h9;
  localparam char_t OPA_ADM = 4'hB;
  localparam char_t OPA_RD0 = 4'hC;

  // Opcodes that put a RAM or status character on the bus during X2.
  function automatic logic is_read_op(input char_t opa);
    return (opa == OPA_SBM) || (opa == OPA_RDM) || (opa == OPA_ADM) ||
           (opa[3:2] == OPA_RD0[3:2]);
  endfunction

  function automatic logic is_status_wr(input char_t opa);
    return opa[3:2] == OPA_WR0[3:2];
  endfunction

endpackage

// File: rtl/mcs4_phase_tracker.sv
// Follows the 8-phase MCS-4 instruction cycle from sync; shared by the ROM/RAM
// responders and bus monitors. The current phase is the registered output.
module mcs4_phase_tracker
  import mcs4::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   clken_2,
  input  logic   sync,
  output phase_t phase
);

  phase_t r_phase;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_phase <= WAIT;
    end else if (clken_2) begin
      if (sync) begin
        r_phase <= A1;
      end else begin
        case (r_phase)
          WAIT:    r_phase <= WAIT;
          A1:      r_phase <= A2;
          A2:      r_phase <= A3;
          A3:      r_phase <= M1;
          M1:      r_phase <= M2;
          M2:      r_phase <= X1;
          X1:      r_phase <= X2;
          X2:      r_phase <= X3;
          X3:      r_phase <= X3;  // a late sync holds the cycle in X3
          default: r_phase <= WAIT;
        endcase
      end
    end
  end

  assign phase = r_phase;

endmodule

// File: rtl/i4002.sv
// MCS-4 4002 data RAM and output port: answers cm_ram for SRC selection and the
// OPR=E I/O group. Status characters exist only when MCS4_RAM_STATUS_EN is defined.
//
// Bus handshake: dbus_en is the valid for dbus_out. It rises on the first clken_1
// of X2 after a read was armed at the end of X1, and drops with dbus_out on the
// clken_2 that ends X2. There is no ready; the top level muxes the bus on dbus_en.
module i4002
  import mcs4::*;
#(
  parameter logic [1:0] CHIP_ID = 2'd0
)
(
  input  logic   clk,
  input  logic   rst,
  input  logic   clken_1,
  input  logic   clken_2,
  input  logic   sync,
  input  logic   cm_ram,
  input  char_t  dbus_in,
  output char_t  dbus_out,
  output logic   dbus_en,
  output char_t  io_out,
  output phase_t o_phase
);

  phase_t   w_phase;
  logic     w_early_sync;
  logic     w_exec;
  logic     w_x2_commit;
  char_t    w_main_rd;
  char_t    w_stat_rd;
  char_t    w_rd_data;

  char_t    r_opr;
  char_t    r_opa;
  logic     r_io_pend;
  logic     r_src_pend;
  logic     r_sel;
  ram_reg_t r_reg_q;
  char_t    r_chr_q;
  logic     r_rd_arm;
  char_t    r_dbus_out;
  logic     r_dbus_en;
  char_t    r_io_out;

  char_t    r_ram [4][16];

  mcs4_phase_tracker u_phase (
    .clk     (clk),
    .rst     (rst),
    .clken_2 (clken_2),
    .sync    (sync),
    .phase   (w_phase)
  );

  // sync outside X3 restarts the cycle; nothing from the aborted instruction runs.
  assign w_early_sync = clken_2 && sync && (w_phase != X3);
  assign w_exec       = r_io_pend && r_sel;
  assign w_x2_commit  = clken_2 && !w_early_sync && (w_phase == X2) && w_exec;
  assign w_main_rd    = r_ram[r_reg_q][r_chr_q];
  assign w_rd_data    = (r_opa[3:2] == OPA_RD0[3:2]) ? w_stat_rd : w_main_rd;

  always_ff @(posedge clk) begin
    if (w_x2_commit && (r_opa == OPA_WRM)) begin
      r_ram[r_reg_q][r_chr_q] <= dbus_in;
    end
  end

`ifdef MCS4_RAM_STATUS_EN
  char_t r_stat [4][4];

  always_ff @(posedge clk) begin
    if (w_x2_commit && is_status_wr(r_opa)) begin
      r_stat[r_reg_q][r_opa[1:0]] <= dbus_in;
    end
  end

  assign w_stat_rd = r_stat[r_reg_q][r_opa[1:0]];
`else
  assign w_stat_rd = '0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_opr      <= '0;
      r_opa      <= '0;
      r_io_pend  <= 1'b0;
      r_src_pend <= 1'b0;
      r_sel      <= 1'b0;
      r_reg_q    <= '0;
      r_chr_q    <= '0;
      r_rd_arm   <= 1'b0;
      r_dbus_out <= '0;
      r_dbus_en  <= 1'b0;
      r_io_out   <= '0;
    end else begin
      if (clken_1 && r_rd_arm) begin
        r_dbus_en <= 1'b1;
      end
      if (w_early_sync) begin
        r_io_pend  <= 1'b0;
        r_src_pend <= 1'b0;
        r_rd_arm   <= 1'b0;
        r_dbus_en  <= 1'b0;
        r_dbus_out <= '0;
      end else if (clken_2) begin
        case (w_phase)
          M1: r_opr <= dbus_in;
          M2: begin
            r_opa     <= dbus_in;
            r_io_pend <= cm_ram && (r_opr == OPR_IO);
          end
          X1: begin
            if (w_exec && is_read_op(r_opa)) begin
              r_dbus_out <= w_rd_data;
              r_rd_arm   <= 1'b1;
            end
          end
          X2: begin
            r_rd_arm   <= 1'b0;
            r_dbus_en  <= 1'b0;
            r_dbus_out <= '0;
            if (cm_ram && !r_io_pend) begin
              r_sel      <= (dbus_in[3:2] == CHIP_ID);
              r_reg_q    <= dbus_in[1:0];
              r_src_pend <= 1'b1;
            end
            if (w_exec && (r_opa == OPA_WMP)) begin
              r_io_out <= dbus_in;
            end
          end
          X3: begin
            r_io_pend <= 1'b0;
            if (r_src_pend) begin
              r_chr_q    <= dbus_in;
              r_src_pend <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign dbus_out = r_dbus_out;
  assign dbus_en  = r_dbus_en;
  assign io_out   = r_io_out;
  assign o_phase  = w_phase;

endmodule
